// File: rtl/compare_fault_qualifier.sv
// compare_fault_qualifier
//   Debounces the over-high / under-low bits coming from CH compare_LH
//   instances, latches sticky fault flags, and drives one protection trip
//   output. Clearing takes an explicit ack_i and finishes only once every
//   monitored input is clean.
//
// Optional feature macro: COMPARE_FAULT_LOG_EN (adds first_o and trip_count_o)
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   compare_i     bit 2k = ch k above H, bit 2k+1 = ch k below L
//   mask_i        1 = bit monitored, 0 = ignored (its counter is held at 0)
//   ack_i         clear request, single-cycle pulse
//   fault_o       registered trip output (1 in TRIPPED and REARM)
//   flags_o       sticky qualified-fault flags
//   state_o       0=ARMED, 1=TRIPPED, 2=REARM
//   first_o       qualified vector captured at the last trip   (log build)
//   trip_count_o  saturating trip counter                      (log build)
module compare_fault_qualifier #(
  parameter int unsigned CH       = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2*CH-1:0] compare_i,
  input  logic [2*CH-1:0] mask_i,
  input  logic            ack_i,
  output logic            fault_o,
  output logic [2*CH-1:0] flags_o,
  output logic [1:0]      state_o
`ifdef COMPARE_FAULT_LOG_EN
  ,
  output logic [2*CH-1:0] first_o,
  output logic [15:0]     trip_count_o
`endif
);

  localparam int unsigned NB = 2 * CH;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRIPPED = 2'd1,
    REARM   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_fault;
  logic [NB-1:0]   r_flags;
  logic [NB-1:0]   w_flags_nxt;
  logic [NB-1:0]   w_act;
  logic [NB-1:0]   w_qual;
  logic [CW-1:0]   r_cnt [NB];

  // A bit qualifies on the edge where it is active with a saturated counter,
  // i.e. its DEBOUNCE-th consecutive active edge.
  always_comb begin
    w_act = compare_i & mask_i;
    for (int k = 0; k < int'(NB); k++) begin
      w_qual[k] = w_act[k] && (r_cnt[k] == CNT_MAX);
    end
  end

  // Per-bit debounce counters, saturating at DEBOUNCE-1; run in every state.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < int'(NB); k++) begin
      if (rst_i || !w_act[k]) begin
        r_cnt[k] <= '0;
      end else if (r_cnt[k] != CNT_MAX) begin
        r_cnt[k] <= r_cnt[k] + CW'(1);
      end
    end
  end

  // Next-state and flag update.
  always_comb begin
    w_state_nxt = r_state;
    w_flags_nxt = r_flags | w_qual;
    case (r_state)
      ARMED: begin
        if (|w_qual) w_state_nxt = TRIPPED;
      end
      TRIPPED: begin
        if (ack_i) begin
          // Old flags are dropped; anything qualifying right now is kept.
          w_flags_nxt = w_qual;
          w_state_nxt = (|w_qual) ? TRIPPED : REARM;
        end
      end
      REARM: begin
        if (|w_qual)     w_state_nxt = TRIPPED;
        else if (|w_act) w_state_nxt = REARM;
        else             w_state_nxt = ARMED;
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  // State and output registers; fault follows the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARMED;
      r_flags <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flags <= w_flags_nxt;
      r_fault <= (w_state_nxt != ARMED);
    end
  end

  assign fault_o = r_fault;
  assign flags_o = r_flags;
  assign state_o = r_state;

`ifdef COMPARE_FAULT_LOG_EN
  logic [NB-1:0] r_first;
  logic [15:0]   r_trip_count;
  logic          w_trip_entry;

  // Only entries from ARMED/REARM count; an ack that stays TRIPPED does not.
  assign w_trip_entry = (r_state != TRIPPED) && (w_state_nxt == TRIPPED);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_first      <= '0;
      r_trip_count <= '0;
    end else if (w_trip_entry) begin
      r_first <= w_qual;
      if (r_trip_count != 16'hFFFF) r_trip_count <= r_trip_count + 16'd1;
    end
  end

  assign first_o      = r_first;
  assign trip_count_o = r_trip_count;
`endif

endmodule

// File: tb/tb_compare_fault_qualifier.sv
// Directed, table-driven bench for compare_fault_qualifier (CH=4, DEBOUNCE=8).
// Each record holds inputs for n consecutive cycles; outputs are checked
// after the last of those cycles.
module tb_compare_fault_qualifier;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] compare_i;
  logic [7:0] mask_i;
  logic       ack_i;
  logic       fault_o;
  logic [7:0] flags_o;
  logic [1:0] state_o;
`ifdef COMPARE_FAULT_LOG_EN
  logic [7:0]  first_o;
  logic [15:0] trip_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  compare_fault_qualifier #(.CH(4), .DEBOUNCE(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .compare_i (compare_i),
    .mask_i    (mask_i),
    .ack_i     (ack_i),
    .fault_o   (fault_o),
    .flags_o   (flags_o),
    .state_o   (state_o)
`ifdef COMPARE_FAULT_LOG_EN
    ,
    .first_o      (first_o),
    .trip_count_o (trip_count_o)
`endif
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] cmp;
    logic [7:0] mask;
    logic       ack;
    int         n;
    logic [7:0] e_flags;
    logic       e_fault;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic [7:0] c,
                     input logic [7:0] m, input logic a, input int n,
                     input logic [7:0] ef, input logic efl, input logic [1:0] es);
    vec_t v;
    v.name = nm; v.rst = r; v.cmp = c; v.mask = m; v.ack = a; v.n = n;
    v.e_flags = ef; v.e_fault = efl; v.e_state = es;
    vecs.push_back(v);
  endtask

  // Drive inputs at negedge, take the posedge, sample 1 time unit later.
  task automatic step(input logic r, input logic [7:0] c, input logic [7:0] m,
                      input logic a);
    @(negedge clk_i);
    rst_i = r; compare_i = c; mask_i = m; ack_i = a;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string nm, input logic [7:0] ef,
                           input logic efl, input logic [1:0] es);
    checks++;
    if (flags_o !== ef || fault_o !== efl || state_o !== es) begin
      errors++;
      $display("FAIL %s: got flags=%h fault=%b state=%0d, want flags=%h fault=%b state=%0d",
               nm, flags_o, fault_o, state_o, ef, efl, es);
    end
  endtask

`ifdef COMPARE_FAULT_LOG_EN
  task automatic check_log(input string nm, input logic [7:0] ef, input logic [15:0] ec);
    checks++;
    if (first_o !== ef || trip_count_o !== ec) begin
      errors++;
      $display("FAIL %s: got first=%h count=%0d, want first=%h count=%0d",
               nm, first_o, trip_count_o, ef, ec);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; compare_i = '0; mask_i = 8'hFF; ack_i = 1'b0;

    //   name            rst cmp    mask   ack n    flags  flt st
    add("reset",          1, 8'h00, 8'hFF, 0, 2,   8'h00, 0, 0);
    // short burst never qualifies
    add("t1_7cyc",        0, 8'h01, 8'hFF, 0, 7,   8'h00, 0, 0);
    add("t1_drop",        0, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    // 8th consecutive edge trips
    add("t2_7cyc",        0, 8'h01, 8'hFF, 0, 7,   8'h00, 0, 0);
    add("t2_8th",         0, 8'h01, 8'hFF, 0, 1,   8'h01, 1, 1);
    // second bit accumulates while TRIPPED
    add("t3_b3_7",        0, 8'h09, 8'hFF, 0, 7,   8'h01, 1, 1);
    add("t3_b3_8",        0, 8'h09, 8'hFF, 0, 1,   8'h09, 1, 1);
    // ack while bit3 still qualifying: stays TRIPPED, keeps only bit3
    add("t3_ack_qual",    0, 8'h08, 8'hFF, 1, 1,   8'h08, 1, 1);
    add("t3_drop",        0, 8'h00, 8'hFF, 0, 1,   8'h08, 1, 1);
    add("t3_b3_again",    0, 8'h08, 8'hFF, 0, 2,   8'h08, 1, 1);
    // ack while bit3 active but not qualified: REARM, flags cleared
    add("t3_ack_rearm",   0, 8'h08, 8'hFF, 1, 1,   8'h00, 1, 2);
    add("t3_rearm_hold",  0, 8'h08, 8'hFF, 0, 1,   8'h00, 1, 2);
    add("t3_armed",       0, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("armed_ack",      0, 8'h00, 8'hFF, 1, 1,   8'h00, 0, 0);
    // REARM -> TRIPPED without re-requiring clean cycles
    add("rt_trip",        0, 8'h10, 8'hFF, 0, 8,   8'h10, 1, 1);
    add("rt_b5_3",        0, 8'h20, 8'hFF, 0, 3,   8'h10, 1, 1);
    add("rt_ack",         0, 8'h20, 8'hFF, 1, 1,   8'h00, 1, 2);
    add("rt_rearm",       0, 8'h20, 8'hFF, 0, 3,   8'h00, 1, 2);
    add("rt_retrip",      0, 8'h20, 8'hFF, 0, 1,   8'h20, 1, 1);
    // masking
    add("t4_rst",         1, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("t4_masked",      0, 8'h01, 8'hFE, 0, 100, 8'h00, 0, 0);
    add("t4_unmask7",     0, 8'h01, 8'hFF, 0, 7,   8'h00, 0, 0);
    add("t4_unmask8",     0, 8'h01, 8'hFF, 0, 1,   8'h01, 1, 1);
    add("t4_mask_keep",   0, 8'h01, 8'h00, 0, 1,   8'h01, 1, 1);
    // reset mid-count and mid-TRIPPED
    add("t5_rst",         1, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("t5_5act",        0, 8'h04, 8'hFF, 0, 5,   8'h00, 0, 0);
    add("t5_rst_mid",     1, 8'h04, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("t5_3more",       0, 8'h04, 8'hFF, 0, 3,   8'h00, 0, 0);
    add("t5_7th",         0, 8'h04, 8'hFF, 0, 4,   8'h00, 0, 0);
    add("t5_8th",         0, 8'h04, 8'hFF, 0, 1,   8'h04, 1, 1);
    add("t5_rst_trip",    1, 8'h04, 8'hFF, 0, 1,   8'h00, 0, 0);
    // simultaneous qualifications
    add("sim_clear",      0, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("sim_c0",         0, 8'hC0, 8'hFF, 0, 8,   8'hC0, 1, 1);
    // one inactive cycle restarts the count
    add("gap_rst",        1, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("gap_6",          0, 8'h02, 8'hFF, 0, 6,   8'h00, 0, 0);
    add("gap_hole",       0, 8'h00, 8'hFF, 0, 1,   8'h00, 0, 0);
    add("gap_7",          0, 8'h02, 8'hFF, 0, 7,   8'h00, 0, 0);
    add("gap_8",          0, 8'h02, 8'hFF, 0, 1,   8'h02, 1, 1);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++)
        step(vecs[i].rst, vecs[i].cmp, vecs[i].mask, vecs[i].ack);
      check_out(vecs[i].name, vecs[i].e_flags, vecs[i].e_fault, vecs[i].e_state);
    end

`ifdef COMPARE_FAULT_LOG_EN
    step(1, 8'h00, 8'hFF, 0);
    check_log("log_reset", 8'h00, 16'd0);
    for (int j = 0; j < 8; j++) step(0, 8'h03, 8'hFF, 0);
    check_out("log_trip1", 8'h03, 1, 1);
    check_log("log_trip1", 8'h03, 16'd1);
    step(0, 8'h00, 8'hFF, 1);
    check_out("log_ack", 8'h00, 1, 2);
    check_log("log_ack", 8'h03, 16'd1);
    step(0, 8'h00, 8'hFF, 0);
    check_out("log_armed", 8'h00, 0, 0);
    for (int j = 0; j < 8; j++) step(0, 8'h10, 8'hFF, 0);
    check_out("log_trip2", 8'h10, 1, 1);
    check_log("log_trip2", 8'h10, 16'd2);
    step(0, 8'h10, 8'hFF, 1);
    check_out("log_ack_qual", 8'h10, 1, 1);
    check_log("log_ack_qual", 8'h10, 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
